// File: rtl/sap1_pkg.sv
// Shared SAP-1 control-path constants: opcode encodings and one-hot T-states.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/sequenciador_sap1_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector producing a one-cycle pulse.
module sync_edge (
  input  logic clk,
  input  logic n_clr,
  input  logic d,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/sequenciador_sap1.sv
// SAP-1 T-state ring: opcode-dependent instruction length, HLT freeze,
// free-run or single-step advance, and a retired-instruction counter.
module sequenciador_sap1
  import sap1_pkg::*;
#(
  parameter int COUNT_W   = 8,
  parameter bit EARLY_END = 1'b1
) (
  input  logic               clk,
  input  logic               n_clr,
  input  logic               run,
  input  logic               step,
  input  logic [3:0]         opcode,
  output logic [5:0]         t,
  output logic               halted,
  output logic               instr_done,
  output logic [COUNT_W-1:0] instr_count
);

  logic       step_pulse;
  logic       adv;
  logic       retire;
  logic [5:0] t_q, t_d;
  logic       halted_q, halted_d;

  sync_edge u_step (
    .clk   (clk),
    .n_clr (n_clr),
    .d     (step),
    .pulse (step_pulse)
  );

  assign adv = ~halted_q & (run | step_pulse);

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      t_q         <= T1;
      halted_q    <= 1'b0;
      instr_done  <= 1'b0;
      instr_count <= '0;
    end else begin
      t_q        <= t_d;
      halted_q   <= halted_d;
      instr_done <= retire;
      if (retire) instr_count <= instr_count + COUNT_W'(1);
    end
  end

  always_comb begin
    t_d      = t_q;
    halted_d = halted_q;
    retire   = 1'b0;
    case (t_q)
      T1: if (adv) t_d = T2;
      T2: if (adv) t_d = T3;
      T3: if (adv) t_d = T4;
      T4: if (adv) begin
        if (opcode == OP_HLT) begin
          t_d      = '0;
          halted_d = 1'b1;
        end else if (EARLY_END && opcode != OP_LDA && !is_alu(opcode)) begin
          t_d    = T1;
          retire = 1'b1;
        end else begin
          t_d = T5;
        end
      end
      // With early end only the ALU ops still need T6 at this point
      T5: if (adv) begin
        if (EARLY_END && !is_alu(opcode)) begin
          t_d    = T1;
          retire = 1'b1;
        end else begin
          t_d = T6;
        end
      end
      T6: if (adv) begin
        t_d    = T1;
        retire = 1'b1;
      end
      default: if (!halted_q) t_d = T1;
    endcase
  end

  always_comb begin
    t      = t_q;
    halted = halted_q;
  end

endmodule

// File: tb/tb_sequenciador_sap1.sv
// Randomized bench for sequenciador_sap1: two instances (early-end/4-bit count and
// full-length/8-bit count) checked against a phase/length reference model.
module tb_sequenciador_sap1;

  logic       clk = 1'b0;
  logic       n_clr = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [3:0] opcode = 4'b0000;

  logic [5:0] t_a, t_b;
  logic       halted_a, halted_b, done_a, done_b;
  logic [3:0] cnt_a;
  logic [7:0] cnt_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sequenciador_sap1 #(.COUNT_W(4), .EARLY_END(1'b1)) dut_a (
    .clk(clk), .n_clr(n_clr), .run(run), .step(step), .opcode(opcode),
    .t(t_a), .halted(halted_a), .instr_done(done_a), .instr_count(cnt_a)
  );

  sequenciador_sap1 #(.COUNT_W(8), .EARLY_END(1'b0)) dut_b (
    .clk(clk), .n_clr(n_clr), .run(run), .step(step), .opcode(opcode),
    .t(t_b), .halted(halted_b), .instr_done(done_b), .instr_count(cnt_b)
  );

  logic [5:0] ot [2];
  logic       oh [2];
  logic       od [2];
  logic [7:0] oc [2];

  always_comb begin
    ot[0] = t_a;      ot[1] = t_b;
    oh[0] = halted_a; oh[1] = halted_b;
    od[0] = done_a;   od[1] = done_b;
    oc[0] = {4'b0, cnt_a};
    oc[1] = cnt_b;
  end

  // Reference model: phase number 1..6, halt flag, retire pulse, count
  int ph [2];
  bit hl [2];
  bit dn [2];
  int cnt [2];
  bit early [2] = '{1'b1, 1'b0};
  int cmask [2] = '{15, 255};
  bit h1, h2, h3;

  function automatic int last_phase(input logic [3:0] op, input bit e);
    if (op == 4'b0001 || op == 4'b0010) return 6;
    if (op == 4'b0000) return e ? 5 : 6;
    return e ? 4 : 6;
  endfunction

  function automatic logic [5:0] exp_t(input int k);
    logic [5:0] one;
    one = 6'b000001;
    return hl[k] ? 6'b0 : (one << (ph[k] - 1));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 1; hl[k] = 1'b0; dn[k] = 1'b0; cnt[k] = 0;
    end
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
  endtask

  task automatic model_edge();
    bit pulse;
    if (!n_clr) begin
      model_reset();
      return;
    end
    pulse = h2 & ~h3;
    for (int k = 0; k < 2; k++) begin
      dn[k] = 1'b0;
      if (!hl[k] && (run || pulse)) begin
        if (ph[k] == 4 && opcode == 4'b1111) hl[k] = 1'b1;
        else if (ph[k] >= 4 && ph[k] >= last_phase(opcode, early[k])) begin
          ph[k] = 1; dn[k] = 1'b1; cnt[k] = (cnt[k] + 1) & cmask[k];
        end else ph[k] = ph[k] + 1;
      end
    end
    h3 = h2; h2 = h1; h1 = step;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_clr = 1'b0; run = 1'b1; step = 1'b0; opcode = 4'b0000;
    model_reset();
    repeat (2) cyc();
    for (int k = 0; k < 2; k++) begin
      total++; if (ot[k] !== 6'b000001) begin bad++; $display("FAIL reset_t dut%0d got=%b want=%b", k, ot[k], 6'b000001); end
      total++; if (oh[k] !== 1'b0) begin bad++; $display("FAIL reset_halted dut%0d got=%b want=0", k, oh[k]); end
      total++; if (od[k] !== 1'b0) begin bad++; $display("FAIL reset_done dut%0d got=%b want=0", k, od[k]); end
      total++; if (oc[k] !== 8'd0) begin bad++; $display("FAIL reset_count dut%0d got=%0d want=0", k, oc[k]); end
    end
    n_clr = 1'b1;
  endtask

  task automatic test_lda();
    opcode = 4'b0000; run = 1'b1;
    repeat (14) begin
      cyc();
      for (int k = 0; k < 2; k++) begin
        total++; if (ot[k] !== exp_t(k)) begin bad++; $display("FAIL lda_t dut%0d got=%b want=%b", k, ot[k], exp_t(k)); end
        total++; if (od[k] !== dn[k]) begin bad++; $display("FAIL lda_done dut%0d got=%b want=%b", k, od[k], dn[k]); end
        total++; if (oc[k] !== 8'(cnt[k])) begin bad++; $display("FAIL lda_count dut%0d got=%0d want=%0d", k, oc[k], cnt[k]); end
      end
    end
  endtask

  task automatic test_lengths();
    run = 1'b1;
    for (int i = 0; i < 30; i++) begin
      opcode = (i < 18) ? ((i < 9) ? 4'b0001 : 4'b0010) : 4'b1110;
      cyc();
      for (int k = 0; k < 2; k++) begin
        total++; if (ot[k] !== exp_t(k)) begin bad++; $display("FAIL len_t dut%0d got=%b want=%b", k, ot[k], exp_t(k)); end
        total++; if (od[k] !== dn[k]) begin bad++; $display("FAIL len_done dut%0d got=%b want=%b", k, od[k], dn[k]); end
        total++; if (oc[k] !== 8'(cnt[k])) begin bad++; $display("FAIL len_count dut%0d got=%0d want=%0d", k, oc[k], cnt[k]); end
      end
    end
  endtask

  task automatic test_halt();
    int frozen_a, frozen_b;
    run = 1'b1; opcode = 4'b1111;
    for (int i = 0; i < 12 && !(hl[0] && hl[1]); i++) begin
      cyc();
      for (int k = 0; k < 2; k++) begin
        total++; if (ot[k] !== exp_t(k)) begin bad++; $display("FAIL halt_t dut%0d got=%b want=%b", k, ot[k], exp_t(k)); end
        total++; if (oh[k] !== hl[k]) begin bad++; $display("FAIL halt_flag dut%0d got=%b want=%b", k, oh[k], hl[k]); end
      end
    end
    total++; if (!(hl[0] && hl[1])) begin bad++; $display("FAIL halt_bound model did not halt got=%b%b want=11", hl[0], hl[1]); end
    frozen_a = cnt[0]; frozen_b = cnt[1];
    repeat (20) begin
      run = 1'($urandom); step = 1'($urandom); opcode = 4'($urandom);
      cyc();
      total++; if (t_a !== 6'b0 || t_b !== 6'b0) begin bad++; $display("FAIL halt_freeze_t got=%b/%b want=0", t_a, t_b); end
      total++; if (oc[0] !== 8'(frozen_a) || oc[1] !== 8'(frozen_b)) begin bad++; $display("FAIL halt_freeze_count got=%0d/%0d want=%0d/%0d", oc[0], oc[1], frozen_a, frozen_b); end
      total++; if (done_a !== 1'b0 || done_b !== 1'b0) begin bad++; $display("FAIL halt_done got=%b/%b want=0", done_a, done_b); end
    end
    step = 1'b0;
    n_clr = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      total++; if (ot[k] !== 6'b000001) begin bad++; $display("FAIL halt_clear_t dut%0d got=%b want=000001", k, ot[k]); end
      total++; if (oh[k] !== 1'b0) begin bad++; $display("FAIL halt_clear_flag dut%0d got=%b want=0", k, oh[k]); end
    end
    cyc();
    n_clr = 1'b1;
  endtask

  task automatic test_step();
    run = 1'b0; opcode = 4'b0000;
    for (int i = 0; i < 36; i++) begin
      if (i < 10) step = 1'b1;
      else if (i < 14) step = 1'b0;
      else if (i < 29) step = ((i - 14) % 5) < 2;
      else begin run = 1'b1; step = (i % 2); end
      cyc();
      for (int k = 0; k < 2; k++) begin
        total++; if (ot[k] !== exp_t(k)) begin bad++; $display("FAIL step_t dut%0d cyc%0d got=%b want=%b", k, i, ot[k], exp_t(k)); end
        total++; if (od[k] !== dn[k]) begin bad++; $display("FAIL step_done dut%0d got=%b want=%b", k, od[k], dn[k]); end
      end
    end
    step = 1'b0;
  endtask

  task automatic test_wrap();
    run = 1'b1; opcode = 4'b1110;
    repeat (72) begin
      cyc();
      for (int k = 0; k < 2; k++) begin
        total++; if (ot[k] !== exp_t(k)) begin bad++; $display("FAIL wrap_t dut%0d got=%b want=%b", k, ot[k], exp_t(k)); end
        total++; if (oc[k] !== 8'(cnt[k])) begin bad++; $display("FAIL wrap_count dut%0d got=%0d want=%0d", k, oc[k], cnt[k]); end
      end
    end
  endtask

  task automatic test_async_reset();
    run = 1'b1; opcode = 4'b0000;
    for (int i = 0; i < 12 && ph[0] != 5; i++) cyc();
    total++; if (t_a !== 6'b010000) begin bad++; $display("FAIL arst_reach_t5 got=%b want=010000", t_a); end
    #2 n_clr = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      total++; if (ot[k] !== 6'b000001) begin bad++; $display("FAIL arst_t dut%0d got=%b want=000001", k, ot[k]); end
      total++; if (oc[k] !== 8'd0) begin bad++; $display("FAIL arst_count dut%0d got=%0d want=0", k, oc[k]); end
    end
    cyc();
    n_clr = 1'b1;
  endtask

  task automatic test_random();
    repeat (300) begin
      run = ($urandom_range(3) != 0);
      step = 1'($urandom);
      opcode = 4'($urandom_range(14));
      cyc();
      for (int k = 0; k < 2; k++) begin
        total++; if (ot[k] !== exp_t(k)) begin bad++; $display("FAIL rand_t dut%0d got=%b want=%b", k, ot[k], exp_t(k)); end
        total++; if (oh[k] !== hl[k]) begin bad++; $display("FAIL rand_halted dut%0d got=%b want=%b", k, oh[k], hl[k]); end
        total++; if (od[k] !== dn[k]) begin bad++; $display("FAIL rand_done dut%0d got=%b want=%b", k, od[k], dn[k]); end
        total++; if (oc[k] !== 8'(cnt[k])) begin bad++; $display("FAIL rand_count dut%0d got=%0d want=%0d", k, oc[k], cnt[k]); end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lda();
    test_lengths();
    test_halt();
    test_step();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sequenciador_sap1.md
Name: sequenciador_sap1

Overview:
- Timing and sequencing unit for the SAP-1 control path.
- Generates the one-hot T-state vector t[5:0] that drives the combinational control-word decoder.
- Shortens instruction cycles per opcode, freezes the machine on HLT, and supports free-run or single-T-state step operation from a push-button.
- Sits between the clock/reset source, the instruction register opcode nibble and the control decoder.

Parameters:
- COUNT_W, 8, width of the retired-instruction counter.
- EARLY_END, 1, 1 = return to T1 as soon as the current opcode has no further active states; 0 = always run T1..T6.

Ports:
- clk  input  1  system clock, rising edge.
- n_clr  input  1  asynchronous active-low reset.
- run  input  1  1 = advance every clock; 0 = advance only on a step event.
- step  input  1  asynchronous push-button; each rising edge is one step event.
- opcode  input  4  IR upper nibble; valid from T4 onward.
- t  output  6  one-hot T-state: t[0]=T1 … t[5]=T6; all-zero when halted.
- halted  output  1  machine stopped by HLT.
- instr_done  output  1  one-cycle pulse on the clock where an instruction retires.
- instr_count  output  COUNT_W  retired-instruction count.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - n_clr low asynchronously forces: t=6'b000001, halted=0, instr_done=0, instr_count=0, step synchronizer flops=0.
  - Deassertion is synchronous to the next clk edge; reset mid-instruction or while halted always restarts at T1.
- Advance condition:
  - adv = ~halted & (run | step_pulse).
  - When adv=0, all state holds.
- Ring order (adv=1): T1→T2→T3→T4, then by opcode, sampled at T4/T5:
  - LDA 0000: T4→T5→T1 when EARLY_END=1, else T5→T6→T1.
  - ADD 0001, SUB 0010: T4→T5→T6→T1.
  - OUT 1110 and any undefined opcode: T4→T1 when EARLY_END=1, else full T6.
  - HLT 1111: at T4 with adv=1, next state is HALTED: t=0, halted=1. No instr_done and no count for HLT.
- HALTED:
  - Absorbing state. run, step and opcode are ignored.
  - Only n_clr exits.
- Retirement:
  - On any transition into T1 from T4, T5 or T6, instr_done=1 for exactly that following cycle.
  - instr_count increments by 1 on the same edge and wraps modulo 2^COUNT_W (all-ones → 0).
- Step path:
  - step passes through a 2-flop synchronizer, then rising-edge detect.
  - step_pulse is high for one cycle.
  - Latency: step first sampled high at edge n → step_pulse during cycle after edge n+1 → t advances at edge n+2.
  - Holding step high yields exactly one advance.
  - step_pulse is ignored when run=1 or halted=1. There is no queuing.
- Mode changes:
  - A run change applies to the very next edge, including mid-instruction.
  - Switching run 1→0 freezes at the current T-state.
- Invariants:
  - t is one-hot, or all-zero only when halted=1.
  - The illegal/all-zero encoding with halted=0 recovers to T1 on the next edge.
  - An opcode change outside T4/T5 has no effect.

Decomposition:
- Shared package sap1_pkg:
  - Opcode constants OP_LDA=4'b0000, OP_ADD=4'b0001, OP_SUB=4'b0010, OP_OUT=4'b1110, OP_HLT=4'b1111.
  - One-hot constants T1..T6.
  - Shared by this block and the control decoder.
- One sub-module, sync_edge: 2-flop synchronizer plus rising-edge pulse with async active-low clear; ports clk, n_clr, d, pulse.
- Ring/halt logic and counter stay in the top level.

Test Plan:
- Reset and LDA: release n_clr with run=1, opcode=0000, EARLY_END=1 → t sequence 01,02,04,08,10,01. instr_done pulses on the cycle t returns to 01; instr_count=1.
- ADD, SUB and OUT lengths:
  - opcode=0001 → t visits 20 before 01; 6 cycles per instruction.
  - opcode=1110 → 4 cycles per instruction.
  - 3 ADDs + 2 OUTs → instr_count=5.
- HLT: opcode=1111 at T4 → next cycle t=00, halted=1. Toggling step/run for 20 cycles keeps t=00 and instr_count unchanged. Pulsing n_clr low → t=01, halted=0.
- Step mode:
  - run=0, step held high 10 cycles → exactly one advance, occurring 2 edges after first sampling.
  - 3 separate presses → t=01→02→04→08.
  - step while run=1 → no extra advance.
- Wrap and reset mid-operation:
  - COUNT_W=4, 16 OUT instructions → instr_count 15→0.
  - n_clr asserted asynchronously mid-T5 → t=01 immediately, before the next clk edge.
